// File: rtl/simplepulsegenerator.sv
// Test-pulse source: a main pulse at a programmed COUNT bin, an optional afterpulse
// train, and an optional short pre-trigger noise glitch.
module simplepulsegenerator #(
    parameter int unsigned NOISE_LEAD  = 8,
    parameter int unsigned NOISE_WIDTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] COUNT,
    input  logic [2:0]  GLOBAL_STATE,
    input  logic [15:0] START,
    input  logic [15:0] WIDTH,
    input  logic [3:0]  NAFTER,
    input  logic [15:0] AFTER_GAP,
    input  logic [7:0]  AFTER_WIDTH,
    input  logic        NOISE_EN,
    output logic        PULSE,
    output logic        BUSY,
    output logic        DONE,
    output logic [4:0]  SENT
);

    typedef enum logic [2:0] {
        sIDLE,
        sARMED,
        sMAIN,
        sGAP,
        sAFTER,
        sDONE
    } state_t;

    state_t      state, state_n;
    logic        pulse_q, pulse_n;
    logic [4:0]  sent_q, sent_n;
    logic [15:0] cnt_q, cnt_n;
    logic [3:0]  aidx_q, aidx_n;
    logic [7:0]  noise_q, noise_n;

    logic [15:0] start_l, start_ln;
    logic [15:0] width_l, width_ln;
    logic [3:0]  nafter_l, nafter_ln;
    logic [15:0] gap_l, gap_ln;
    logic [7:0]  awidth_l, awidth_ln;
    logic        noise_en_l, noise_en_ln;

    logic [15:0] width_m1, gap_m1, awidth_m1, noise_bin;
    logic [4:0]  sent_inc;

    // Down-counters load (length - 1) so a zero length behaves as one cycle.
    assign width_m1  = (width_l == '0) ? '0 : width_l - 16'd1;
    assign gap_m1    = (gap_l == '0) ? '0 : gap_l - 16'd1;
    assign awidth_m1 = (awidth_l == '0) ? '0 : {8'd0, awidth_l} - 16'd1;
    assign noise_bin = start_l - 16'(NOISE_LEAD);
    assign sent_inc  = (sent_q == 5'd16) ? sent_q : sent_q + 5'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= sIDLE;
            pulse_q    <= 1'b0;
            sent_q     <= '0;
            cnt_q      <= '0;
            aidx_q     <= '0;
            noise_q    <= '0;
            start_l    <= '0;
            width_l    <= '0;
            nafter_l   <= '0;
            gap_l      <= '0;
            awidth_l   <= '0;
            noise_en_l <= 1'b0;
        end else begin
            state      <= state_n;
            pulse_q    <= pulse_n;
            sent_q     <= sent_n;
            cnt_q      <= cnt_n;
            aidx_q     <= aidx_n;
            noise_q    <= noise_n;
            start_l    <= start_ln;
            width_l    <= width_ln;
            nafter_l   <= nafter_ln;
            gap_l      <= gap_ln;
            awidth_l   <= awidth_ln;
            noise_en_l <= noise_en_ln;
        end
    end

    always_comb begin
        state_n     = state;
        pulse_n     = pulse_q;
        sent_n      = sent_q;
        cnt_n       = cnt_q;
        aidx_n      = aidx_q;
        noise_n     = noise_q;
        start_ln    = start_l;
        width_ln    = width_l;
        nafter_ln   = nafter_l;
        gap_ln      = gap_l;
        awidth_ln   = awidth_l;
        noise_en_ln = noise_en_l;

        if (GLOBAL_STATE == 3'b000) begin
            state_n = sIDLE;
            pulse_n = 1'b0;
            noise_n = '0;
        end else begin
            case (state)
                sIDLE: begin
                    pulse_n = 1'b0;
                    if (GLOBAL_STATE == 3'b001) begin
                        start_ln    = START;
                        width_ln    = WIDTH;
                        nafter_ln   = NAFTER;
                        gap_ln      = AFTER_GAP;
                        awidth_ln   = AFTER_WIDTH;
                        noise_en_ln = NOISE_EN;
                        sent_n      = '0;
                        aidx_n      = '0;
                        noise_n     = '0;
                        state_n     = sARMED;
                    end
                end
                sARMED: begin
                    // Main launch wins over any glitch still in progress.
                    if (COUNT == start_l) begin
                        pulse_n = 1'b1;
                        cnt_n   = width_m1;
                        sent_n  = sent_inc;
                        noise_n = '0;
                        state_n = sMAIN;
                    end else if (noise_q != '0) begin
                        noise_n = noise_q - 8'd1;
                        pulse_n = (noise_q > 8'd1);
                    end else if (noise_en_l && (COUNT == noise_bin)) begin
                        noise_n = 8'(NOISE_WIDTH);
                        pulse_n = 1'b1;
                    end
                end
                sMAIN: begin
                    if (cnt_q == '0) begin
                        pulse_n = 1'b0;
                        if (nafter_l == '0) begin
                            state_n = sDONE;
                        end else begin
                            cnt_n   = gap_m1;
                            state_n = sGAP;
                        end
                    end else begin
                        cnt_n = cnt_q - 16'd1;
                    end
                end
                sGAP: begin
                    if (cnt_q == '0) begin
                        pulse_n = 1'b1;
                        cnt_n   = awidth_m1;
                        aidx_n  = aidx_q + 4'd1;
                        sent_n  = sent_inc;
                        state_n = sAFTER;
                    end else begin
                        cnt_n = cnt_q - 16'd1;
                    end
                end
                sAFTER: begin
                    if (cnt_q == '0) begin
                        pulse_n = 1'b0;
                        if (aidx_q == nafter_l) begin
                            state_n = sDONE;
                        end else begin
                            cnt_n   = gap_m1;
                            state_n = sGAP;
                        end
                    end else begin
                        cnt_n = cnt_q - 16'd1;
                    end
                end
                sDONE: begin
                    pulse_n = 1'b0;
                end
                default: begin
                    state_n = sIDLE;
                    pulse_n = 1'b0;
                end
            endcase
        end
    end

    assign PULSE = pulse_q;
    assign BUSY  = (state == sARMED) || (state == sMAIN) || (state == sGAP) || (state == sAFTER);
    assign DONE  = (state == sDONE);
    assign SENT  = sent_q;

endmodule

// File: doc/simplepulsegenerator.md
# simplepulsegenerator

Test-pulse source that drives a single-bit PULSE line in bin time. It is the transmit-side counterpart of the pulse reader. It emits one main pulse of programmable width at a programmed COUNT bin, then an optional train of afterpulses, and optionally a short pre-trigger noise glitch. Its output connects to the reader's PULSE input in loopback benches and on the board's self-test path. It shares the global COUNT timebase and GLOBAL_STATE bus with the reader.

## Interface
- NOISE_LEAD, 8: bins before START at which the noise glitch begins; must exceed NOISE_WIDTH.
- NOISE_WIDTH, 2: noise glitch high time in cycles; kept below the reader's long-pulse threshold (>5).
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- COUNT  input  16  global bin counter (free-running, wraps).
- GLOBAL_STATE  input  3  3'b000 soft reset, 3'b001 waiting (arm); other codes are ignored.
- START  input  16  bin at which the main pulse is launched.
- WIDTH  input  16  main pulse high time in cycles; 0 is treated as 1.
- NAFTER  input  4  number of afterpulses, 0–15.
- AFTER_GAP  input  16  low time before each afterpulse; 0 is treated as 1.
- AFTER_WIDTH  input  8  afterpulse high time; 0 is treated as 1.
- NOISE_EN  input  1  emit the noise glitch before the main pulse.
- PULSE  output  1  registered pulse line.
- BUSY  output  1  high from arm until the last pulse falls.
- DONE  output  1  high once the sequence completes; holds until soft reset or RESET.
- SENT  output  5  count of pulses emitted in this sequence, main plus afterpulses; noise is not counted.

## Operation
- States: sIDLE, sARMED, sMAIN, sGAP, sAFTER, sDONE.
- sIDLE:
  - If GLOBAL_STATE==3'b001, latch START, WIDTH, NAFTER, AFTER_GAP, AFTER_WIDTH and NOISE_EN, clear SENT, and go to sARMED.
  - Config inputs are ignored after arming.
- sARMED, main launch: on COUNT==START_latched, load the width counter, set PULSE, increment SENT, and go to sMAIN.
- sARMED, noise glitch:
  - Applies only if NOISE_EN_latched.
  - On COUNT==(START_latched−NOISE_LEAD) mod 2^16, a side counter drives PULSE high for NOISE_WIDTH cycles.
  - The state stays sARMED during the glitch.
- sMAIN: PULSE is high; after the latched width (min 1) expires, PULSE goes low.
  - If NAFTER==0, go to sDONE.
  - Otherwise go to sGAP.
- sGAP: PULSE is low for the gap (min 1). Then set PULSE, increment SENT, and go to sAFTER.
- sAFTER: PULSE is high for AFTER_WIDTH (min 1), then low.
  - If the afterpulse count emitted equals NAFTER, go to sDONE.
  - Otherwise go to sGAP.
- sDONE: PULSE=0, DONE=1, BUSY=0. The block stays here until GLOBAL_STATE==3'b000. It does not re-arm while GLOBAL_STATE remains 3'b001.
- Soft reset: GLOBAL_STATE==3'b000 in any state means next cycle sIDLE, PULSE=0, DONE=0, BUSY=0, and the noise counter is cleared. SENT holds its value.
- RESET has priority over soft reset. It gives sIDLE, all outputs 0, SENT=0, and clears all latched config and counters.
- Counter widths: the width and gap counters are 16 bits; the afterpulse index is 4 bits; SENT is 5 bits and never wraps (max 16).

## Timing
- Reset values: PULSE=0, BUSY=0, DONE=0, SENT=0, state sIDLE.
- Arm latency: GLOBAL_STATE==3'b001 sampled at edge k gives BUSY=1 from k+1.
- Launch latency: COUNT==START sampled at edge k gives PULSE=1 from k+1 for exactly max(WIDTH,1) cycles.
- Each gap is exactly max(AFTER_GAP,1) low cycles. Each afterpulse is exactly max(AFTER_WIDTH,1) high cycles.
- DONE rises and BUSY falls on the same edge where PULSE falls for the final time.
- A noise glitch that still overlaps at main launch is overridden by the main pulse, so PULSE stays high. This cannot occur with legal parameters.
- If COUNT==START is sampled on the same edge the block arms, the launch occurs on the next match, one COUNT wrap later.

## Test plan
- Basic main pulse:
  - Stimulus: arm with START=100, WIDTH=10, NAFTER=0.
  - Required: PULSE high for exactly 10 cycles starting the cycle after COUNT==100; DONE=1 and SENT=1 on the falling edge.
- Afterpulse train:
  - Stimulus: START=50, WIDTH=8, NAFTER=3, AFTER_GAP=4, AFTER_WIDTH=2.
  - Required: high 8, low 4, high 2, low 4, high 2, low 4, high 2; SENT=4; DONE on the last fall.
- Soft reset mid-pulse:
  - Stimulus: GLOBAL_STATE=000 during cycle 5 of a WIDTH=20 pulse.
  - Required: PULSE=0 and BUSY=0 the next cycle; DONE stays 0; re-arm works.
- Noise with wrap-around:
  - Stimulus: NOISE_EN=1, START=16'h0002.
  - Required: 2-cycle glitch after COUNT==16'hFFFA; main pulse after COUNT==2.
- Zero-value fields:
  - Stimulus: WIDTH=0, NAFTER=1, AFTER_GAP=0, AFTER_WIDTH=0.
  - Required: pattern high 1, low 1, high 1; SENT=2.
- Loopback into the pulse reader:
  - Stimulus: WIDTH=12 with NOISE_EN=1.
  - Required: the reader rejects the noise glitch, then triggers with WIDTH reported as 12 and STARTBIN equal to START plus the reader's synchronizer latency.
